// File: rtl/wb_port_arbiter_if.sv
// Register-file write port shared by the pipeline writeback (A) and a multicycle unit (B).
// The arbiter takes the slave side; the sources and the register file take the master side.
interface wb_port_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [63:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [63:0] b_data;
  logic        reg_write;
  logic [4:0]  wr_reg;
  logic [63:0] wr_data;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  b_ready, reg_write, wr_reg, wr_data
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output b_ready, reg_write, wr_reg, wr_data
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Fixed-priority register-file write arbiter with starvation bubble request for source B
// and a pending-write scoreboard for multicycle destinations.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  wb_port_arbiter_if.slave         bus,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_reg,
  input  logic [4:0]               chk_reg1,
  input  logic [4:0]               chk_reg2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic                     stall_req,
  output logic                     err_overrun,
  output logic                     err_dup_issue
);

  typedef enum logic [1:0] {IDLE, WAIT, STALL} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] pending_q, pending_d;
  logic        stall_req_q, stall_req_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  wr_reg_q, wr_reg_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic        err_overrun_q, err_overrun_d;
  logic        err_dup_q, err_dup_d;

  logic        b_xfer;
  logic        contend;
  logic [3:0]  cnt_inc;
  logic        issue_live;

  assign b_xfer     = bus.b_valid && !bus.a_valid;
  assign contend    = bus.b_valid && bus.a_valid;
  assign cnt_inc    = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
  assign issue_live = issue_valid && (issue_reg != 5'd0);

  // Write-port mux: A always wins; writes to x0 still complete but never enable the register file.
  always_comb begin
    reg_write_d = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    if (bus.a_valid) begin
      reg_write_d = (bus.a_reg != 5'd0);
      wr_reg_d    = bus.a_reg;
      wr_data_d   = bus.a_data;
    end else if (b_xfer) begin
      reg_write_d = (bus.b_reg != 5'd0);
      wr_reg_d    = bus.b_reg;
      wr_data_d   = bus.b_data;
    end
  end

  // Starvation tracker: a limit of 1 jumps straight from IDLE to STALL on the first lost edge.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (contend) begin
          wait_cnt_d = 4'd1;
          state_d    = (4'd1 >= LIMIT) ? STALL : WAIT;
        end
      end
      WAIT: begin
        if (b_xfer || !bus.b_valid) begin
          state_d    = IDLE;
          wait_cnt_d = 4'd0;
        end else begin
          wait_cnt_d = cnt_inc;
          if (cnt_inc >= LIMIT) state_d = STALL;
        end
      end
      STALL: begin
        if (b_xfer || !bus.b_valid) begin
          state_d    = IDLE;
          wait_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
    stall_req_d = (state_d == STALL);
  end

  // Scoreboard: clear on B transfer first so a same-cycle issue to that register wins.
  always_comb begin
    pending_d = pending_q;
    if (b_xfer) pending_d[bus.b_reg] = 1'b0;
    if (issue_live) pending_d[issue_reg] = 1'b1;
    pending_d[0] = 1'b0;
    err_overrun_d = err_overrun_q | (bus.a_valid & stall_req_q);
    err_dup_d     = err_dup_q | (issue_live & pending_q[issue_reg]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= 4'd0;
      pending_q     <= 32'd0;
      stall_req_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      wr_reg_q      <= 5'd0;
      wr_data_q     <= 64'd0;
      err_overrun_q <= 1'b0;
      err_dup_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      pending_q     <= pending_d;
      stall_req_q   <= stall_req_d;
      reg_write_q   <= reg_write_d;
      wr_reg_q      <= wr_reg_d;
      wr_data_q     <= wr_data_d;
      err_overrun_q <= err_overrun_d;
      err_dup_q     <= err_dup_d;
    end
  end

  assign bus.b_ready   = !bus.a_valid;
  assign bus.reg_write = reg_write_q;
  assign bus.wr_reg    = wr_reg_q;
  assign bus.wr_data   = wr_data_q;
  assign stall_req     = stall_req_q;
  assign err_overrun   = err_overrun_q;
  assign err_dup_issue = err_dup_q;
  assign hazard1       = (chk_reg1 != 5'd0) && pending_q[chk_reg1];
  assign hazard2       = (chk_reg2 != 5'd0) && pending_q[chk_reg2];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: priority, latency, starvation stall, scoreboard,
// x0 handling, sticky errors and asynchronous reset.
module tb_wb_port_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [4:0] issue_reg, chk_reg1, chk_reg2;
  logic       hazard1, hazard2, stall_req, err_overrun, err_dup_issue;
  int         vectors = 0;
  int         miscompares = 0;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .hazard1(hazard1), .hazard2(hazard2), .stall_req(stall_req),
    .err_overrun(err_overrun), .err_dup_issue(err_dup_issue)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 0; bus.a_reg = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_reg = 0; bus.b_data = 0;
    issue_valid = 0; issue_reg = 0; chk_reg1 = 0; chk_reg2 = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    #12;
    vectors++;
    if ({stall_req, bus.reg_write, bus.wr_reg, bus.wr_data, err_overrun, err_dup_issue, hazard1, hazard2} !== 75'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {stall_req, bus.reg_write, bus.wr_reg, bus.wr_data, err_overrun, err_dup_issue, hazard1, hazard2});
    end
    vectors++;
    if (bus.b_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_b_ready: got %b expected 1", bus.b_ready); end
    rst = 1;
    step();
  endtask

  task automatic test_a_only();
    bus.a_valid = 1; bus.a_reg = 5; bus.a_data = 64'hAA;
    #1;
    vectors++;
    if (bus.b_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL a_only_b_ready: got %b expected 0", bus.b_ready); end
    step();
    vectors++;
    if ({bus.reg_write, bus.wr_reg, bus.wr_data} !== {1'b1, 5'd5, 64'hAA}) begin
      miscompares++; $display("[TB] FAIL a_only_write: got %h expected %h", {bus.reg_write, bus.wr_reg, bus.wr_data}, {1'b1, 5'd5, 64'hAA});
    end
    bus.a_reg = 3; bus.a_data = 64'h3333_0000_0000_0033;
    step();
    vectors++;
    if ({bus.reg_write, bus.wr_reg, bus.wr_data} !== {1'b1, 5'd3, 64'h3333_0000_0000_0033}) begin
      miscompares++; $display("[TB] FAIL back_to_back_write: got %h expected %h", {bus.reg_write, bus.wr_reg, bus.wr_data}, {1'b1, 5'd3, 64'h3333_0000_0000_0033});
    end
    idle_inputs();
    step();
    vectors++;
    if ({bus.reg_write, bus.wr_reg, bus.wr_data} !== {1'b0, 5'd3, 64'h3333_0000_0000_0033}) begin
      miscompares++; $display("[TB] FAIL idle_hold: got %h expected %h", {bus.reg_write, bus.wr_reg, bus.wr_data}, {1'b0, 5'd3, 64'h3333_0000_0000_0033});
    end
  endtask

  task automatic test_b_only();
    bus.b_valid = 1; bus.b_reg = 12; bus.b_data = 64'h1234;
    #1;
    vectors++;
    if (bus.b_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b_only_ready: got %b expected 1", bus.b_ready); end
    step();
    idle_inputs();
    vectors++;
    if ({bus.reg_write, bus.wr_reg, bus.wr_data} !== {1'b1, 5'd12, 64'h1234}) begin
      miscompares++; $display("[TB] FAIL b_only_write: got %h expected %h", {bus.reg_write, bus.wr_reg, bus.wr_data}, {1'b1, 5'd12, 64'h1234});
    end
    step();
  endtask

  task automatic test_reg0();
    bus.b_valid = 1; bus.b_reg = 0; bus.b_data = 64'hFF;
    issue_valid = 1; issue_reg = 0;
    #1;
    vectors++;
    if (bus.b_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL x0_ready: got %b expected 1", bus.b_ready); end
    step();
    idle_inputs();
    vectors++;
    if (bus.reg_write !== 1'b0) begin miscompares++; $display("[TB] FAIL x0_reg_write: got %b expected 0", bus.reg_write); end
    #1;
    vectors++;
    if ({hazard1, hazard2, err_dup_issue} !== 3'b000) begin miscompares++; $display("[TB] FAIL x0_hazard: got %b expected 000", {hazard1, hazard2, err_dup_issue}); end
    step();
  endtask

  task automatic test_contention();
    bus.a_valid = 1; bus.a_reg = 1; bus.a_data = 64'h1;
    bus.b_valid = 1; bus.b_reg = 2; bus.b_data = 64'h22;
    step();
    vectors++;
    if (stall_req !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_edge1: got %b expected 0", stall_req); end
    step();
    vectors++;
    if (stall_req !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_edge2: got %b expected 0", stall_req); end
    step();
    vectors++;
    if ({stall_req, bus.reg_write, bus.wr_reg} !== {1'b1, 1'b1, 5'd1}) begin
      miscompares++; $display("[TB] FAIL stall_edge3: got %b expected %b", {stall_req, bus.reg_write, bus.wr_reg}, {1'b1, 1'b1, 5'd1});
    end
    bus.a_valid = 0;
    step();
    bus.b_valid = 0;
    vectors++;
    if ({stall_req, bus.reg_write, bus.wr_reg, bus.wr_data} !== {1'b0, 1'b1, 5'd2, 64'h22}) begin
      miscompares++; $display("[TB] FAIL starve_release: got %h expected %h", {stall_req, bus.reg_write, bus.wr_reg, bus.wr_data}, {1'b0, 1'b1, 5'd2, 64'h22});
    end
    step();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_reg = 7;
    step();
    issue_valid = 0; chk_reg1 = 7;
    #1;
    vectors++;
    if (hazard1 !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_set: got %b expected 1", hazard1); end
    bus.b_valid = 1; bus.b_reg = 7; bus.b_data = 64'h77;
    step();
    bus.b_valid = 0;
    #1;
    vectors++;
    if (hazard1 !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_clear: got %b expected 0", hazard1); end
    issue_valid = 1; issue_reg = 7;
    bus.b_valid = 1; bus.b_reg = 7;
    step();
    issue_valid = 0; bus.b_valid = 0; chk_reg2 = 7;
    #1;
    vectors++;
    if ({hazard1, hazard2, err_dup_issue} !== 3'b110) begin miscompares++; $display("[TB] FAIL sb_set_wins: got %b expected 110", {hazard1, hazard2, err_dup_issue}); end
    bus.b_valid = 1; bus.b_reg = 7;
    step();
    idle_inputs();
    chk_reg1 = 7;
    #1;
    vectors++;
    if (hazard1 !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_final_clear: got %b expected 0", hazard1); end
    step();
  endtask

  task automatic test_errors();
    bus.a_valid = 1; bus.a_reg = 11; bus.a_data = 64'hB0B;
    bus.b_valid = 1; bus.b_reg = 13; bus.b_data = 64'hD0D;
    step();
    step();
    step();
    vectors++;
    if ({stall_req, err_overrun} !== 2'b10) begin miscompares++; $display("[TB] FAIL overrun_pre: got %b expected 10", {stall_req, err_overrun}); end
    step();
    vectors++;
    if ({err_overrun, stall_req, bus.reg_write, bus.wr_reg, bus.wr_data} !== {1'b1, 1'b1, 1'b1, 5'd11, 64'hB0B}) begin
      miscompares++; $display("[TB] FAIL overrun_set: got %h expected %h", {err_overrun, stall_req, bus.reg_write, bus.wr_reg, bus.wr_data}, {1'b1, 1'b1, 1'b1, 5'd11, 64'hB0B});
    end
    bus.a_valid = 0;
    step();
    bus.b_valid = 0;
    vectors++;
    if ({stall_req, bus.wr_reg, err_overrun} !== {1'b0, 5'd13, 1'b1}) begin
      miscompares++; $display("[TB] FAIL overrun_release: got %b expected %b", {stall_req, bus.wr_reg, err_overrun}, {1'b0, 5'd13, 1'b1});
    end
    issue_valid = 1; issue_reg = 9;
    step();
    vectors++;
    if (err_dup_issue !== 1'b0) begin miscompares++; $display("[TB] FAIL dup_first: got %b expected 0", err_dup_issue); end
    step();
    issue_valid = 0; chk_reg1 = 9;
    #1;
    vectors++;
    if ({err_dup_issue, hazard1} !== 2'b11) begin miscompares++; $display("[TB] FAIL dup_second: got %b expected 11", {err_dup_issue, hazard1}); end
    bus.b_valid = 1; bus.b_reg = 9;
    step();
    idle_inputs();
    step();
    vectors++;
    if ({err_overrun, err_dup_issue} !== 2'b11) begin miscompares++; $display("[TB] FAIL errors_sticky: got %b expected 11", {err_overrun, err_dup_issue}); end
  endtask

  task automatic test_async_reset();
    bus.a_valid = 1; bus.a_reg = 1; bus.a_data = 64'h5;
    bus.b_valid = 1; bus.b_reg = 2; bus.b_data = 64'h6;
    issue_valid = 1; issue_reg = 3;
    step();
    issue_valid = 0; chk_reg1 = 3;
    step();
    step();
    vectors++;
    if ({stall_req, hazard1} !== 2'b11) begin miscompares++; $display("[TB] FAIL ar_pre_stall: got %b expected 11", {stall_req, hazard1}); end
    #2 rst = 0;
    #1;
    vectors++;
    if ({stall_req, bus.reg_write, bus.wr_reg, bus.wr_data, err_overrun, err_dup_issue, hazard1, hazard2} !== 75'd0) begin
      miscompares++; $display("[TB] FAIL ar_immediate: got %h expected 0", {stall_req, bus.reg_write, bus.wr_reg, bus.wr_data, err_overrun, err_dup_issue, hazard1, hazard2});
    end
    idle_inputs();
    #2 rst = 1;
    bus.a_valid = 1; bus.a_reg = 20; bus.a_data = 64'h20;
    bus.b_valid = 1; bus.b_reg = 21; bus.b_data = 64'h21;
    step();
    step();
    vectors++;
    if ({stall_req, bus.reg_write, bus.wr_reg} !== {1'b0, 1'b1, 5'd20}) begin
      miscompares++; $display("[TB] FAIL ar_idle_after: got %b expected %b", {stall_req, bus.reg_write, bus.wr_reg}, {1'b0, 1'b1, 5'd20});
    end
    bus.a_valid = 0;
    step();
    idle_inputs();
    vectors++;
    if ({bus.reg_write, bus.wr_reg, bus.wr_data} !== {1'b1, 5'd21, 64'h21}) begin
      miscompares++; $display("[TB] FAIL ar_first_b: got %h expected %h", {bus.reg_write, bus.wr_reg, bus.wr_data}, {1'b1, 5'd21, 64'h21});
    end
    step();
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_b_only();
    test_reg0();
    test_contention();
    test_scoreboard();
    test_errors();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3; consecutive cycles of lost arbitration after which B forces a pipeline bubble; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 a_valid  in  1  pipeline writeback (source A) write request; A cannot be back-pressured.
REQ-005 a_reg  in  5  A destination register.
REQ-006 a_data  in  64  A write data.
REQ-007 b_valid  in  1  multicycle unit (source B) write request.
REQ-008 b_ready  out  1  B may transfer; combinational, equals !a_valid.
REQ-009 b_reg  in  5  B destination register.
REQ-010 b_data  in  64  B write data.
REQ-011 issue_valid  in  1  a multicycle op targeting issue_reg is issued this cycle.
REQ-012 issue_reg  in  5  destination of the issued multicycle op.
REQ-013 chk_reg1, chk_reg2  in  5 each  decode-stage source registers to check.
REQ-014 hazard1, hazard2  out  1 each  combinational: pending[chk_regN], forced 0 when chk_regN == 0.
REQ-015 stall_req  out  1  registered; requests a bubble on source A.
REQ-016 reg_write  out  1  registered register-file write enable.
REQ-017 wr_reg  out  5  registered register-file write address.
REQ-018 wr_data  out  64  registered register-file write data.
REQ-019 err_overrun  out  1  sticky; A was valid while stall_req was high.
REQ-020 err_dup_issue  out  1  sticky; issue to an already-pending register.

Function
REQ-021 Arbitration SHALL be fixed priority: A wins whenever a_valid = 1; B transfers when b_valid && b_ready.
REQ-022 Write latency SHALL be one cycle: winner's reg/data appear on wr_reg/wr_data with reg_write = 1 the cycle after the request.
REQ-023 A cycle with no transfer SHALL drive reg_write = 0; wr_reg/wr_data hold their previous values.
REQ-024 A transfer targeting register 0 SHALL complete its handshake but drive reg_write = 0.
REQ-025 FSM states: IDLE, WAIT, STALL; reset state IDLE.
REQ-026 IDLE -> WAIT when b_valid && a_valid; wait_cnt loads 1; otherwise stay IDLE.
REQ-027 WAIT: each cycle b_valid && a_valid increments wait_cnt (4 bits, saturating at 15); B transfer or b_valid = 0 returns to IDLE with wait_cnt = 0.
REQ-028 WAIT -> STALL when the incremented wait_cnt reaches STARVE_LIMIT; stall_req = 1 throughout STALL.
REQ-029 STALL -> IDLE when B transfers or b_valid drops; wait_cnt cleared; stall_req falls on that same edge.
REQ-030 In STALL, a_valid = 1 SHALL still win (A priority absolute) and SHALL set err_overrun.
REQ-031 Scoreboard pending[31:0]: issue_valid with issue_reg != 0 sets pending[issue_reg]; a B transfer clears pending[b_reg].
REQ-032 Set and clear of the same register in one cycle: set wins.
REQ-033 issue_valid to a register with pending already set SHALL set err_dup_issue; bit remains set.
REQ-034 pending[0] SHALL be constant 0; A writes never modify pending.
REQ-035 Scoreboard updates SHALL be visible on hazard1/hazard2 the cycle after the causing edge.

Reset
REQ-036 rst = 0 SHALL immediately, without a clock, force: state IDLE, wait_cnt 0, pending all 0, stall_req 0, reg_write 0, wr_reg 0, wr_data 0, err_overrun 0, err_dup_issue 0.
REQ-037 Reset asserted mid-stall or mid-transfer SHALL discard the in-flight write (reg_write 0); the first transfer after release follows REQ-021/022.

Verification
REQ-038 A only: a_valid = 1, a_reg = 5, a_data = 0xAA for one cycle -> next cycle reg_write = 1, wr_reg = 5, wr_data = 0xAA; b_ready = 0 during the request cycle.
REQ-039 Contention, STARVE_LIMIT = 3: a_valid and b_valid held high -> stall_req = 1 after the third losing edge; drop a_valid -> B transfers, next cycle wr_reg = b_reg, stall_req = 0.
REQ-040 Scoreboard: issue_reg = 7, then chk_reg1 = 7 -> hazard1 = 1; B writes reg 7 -> hazard1 = 0 the following cycle; same-cycle issue and B clear of reg 7 -> hazard1 stays 1.
REQ-041 x0: B transfer with b_reg = 0, b_data = 0xFF -> handshake completes, reg_write = 0; issue_reg = 0 -> hazard never asserts.
REQ-042 Errors: a_valid = 1 while stall_req = 1 -> err_overrun = 1 and A written; issue reg 9 twice -> err_dup_issue = 1; both remain set until reset.
REQ-043 Async reset: assert rst = 0 between edges while in STALL with pending[3] = 1 -> all outputs and pending clear immediately; release -> state IDLE.
